// File: rtl/frame_fetch_sequencer.sv
// Streams one frame from SDRAM into the VGA pixel FIFO, throttled by FIFO credit,
// with clean restart when a new frame_start arrives before the current frame finishes.
module frame_fetch_sequencer #(
    parameter int unsigned FRAME_WORDS = 480000,
    parameter logic [24:0] BUF0_BASE   = 25'd0,
    parameter logic [24:0] BUF1_BASE   = 25'd524288,
    parameter int unsigned FIFO_DEPTH  = 512,
    parameter int unsigned USEDW_W     = 9,
    parameter int unsigned MARGIN      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               buffer_select,
    input  logic [USEDW_W-1:0] fifo_wrusedw,
    input  logic               fifo_wrfull,
    output logic               fifo_wrreq,
    output logic [15:0]        fifo_data,
    output logic [24:0]        avm_address,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [15:0]        avm_readdata,
    input  logic               avm_readdatavalid,
    output logic               busy,
    output logic               frame_done,
    output logic [7:0]         late_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam int unsigned    CW           = USEDW_W + 2;
    localparam logic [18:0]    FRAME_LAST   = 19'(FRAME_WORDS);
    localparam logic [CW-1:0]  CREDIT_LIMIT = CW'(FIFO_DEPTH - MARGIN);

    state_t      state;
    logic [24:0] base;
    logic [18:0] issued;
    logic [18:0] written;
    logic [5:0]  outstanding;

    logic          accepted;
    logic          hold;
    logic [CW-1:0] credit_next;
    logic [18:0]   issued_next;
    logic [5:0]    outstanding_next;
    logic          gate_base;
    logic          gate_fetch;
    logic [24:0]   fs_base;
    logic [7:0]    late_next;
    logic          abort_clear;

    // Credit counts every pixel already committed to the FIFO, including a read
    // being accepted right now, so a freshly raised request can never overflow it.
    always_comb begin
        accepted         = avm_read && !avm_waitrequest;
        hold             = avm_read && avm_waitrequest;
        credit_next      = CW'(fifo_wrusedw) + CW'(outstanding) + CW'(fifo_wrreq) + CW'(accepted);
        issued_next      = issued + {18'd0, accepted};
        outstanding_next = outstanding + {5'd0, accepted}
                         - {5'd0, (avm_readdatavalid && (outstanding != 6'd0))};
        gate_base        = (credit_next < CREDIT_LIMIT)
                         && (({1'b0, outstanding} + {6'd0, accepted}) < 7'd32)
                         && !fifo_wrfull;
        gate_fetch       = gate_base && (issued_next < FRAME_LAST);
        fs_base          = buffer_select ? BUF1_BASE : BUF0_BASE;
        late_next        = (late_count == 8'd255) ? 8'd255 : (late_count + 8'd1);
        abort_clear      = (outstanding == 6'd0) && !avm_read && !avm_readdatavalid;
    end

    // Sequencer state, Avalon request, return path and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            base        <= BUF0_BASE;
            issued      <= 19'd0;
            written     <= 19'd0;
            outstanding <= 6'd0;
            avm_address <= 25'd0;
            avm_read    <= 1'b0;
            fifo_wrreq  <= 1'b0;
            fifo_data   <= 16'd0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            late_count  <= 8'd0;
        end else begin
            outstanding <= outstanding_next;
            fifo_wrreq  <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        base        <= fs_base;
                        avm_address <= fs_base;
                        issued      <= 19'd0;
                        written     <= 19'd0;
                        avm_read    <= gate_base;
                        busy        <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (avm_readdatavalid) begin
                        fifo_wrreq <= 1'b1;
                        fifo_data  <= avm_readdata;
                        written    <= written + 19'd1;
                    end
                    if (frame_start) begin
                        late_count <= late_next;
                        base       <= fs_base;
                        avm_read   <= hold;
                        state      <= ABORT;
                    end else begin
                        if (accepted) begin
                            avm_address <= avm_address + 25'd1;
                            issued      <= issued_next;
                        end
                        avm_read <= hold || gate_fetch;
                        if (issued_next == FRAME_LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (avm_readdatavalid) begin
                        fifo_wrreq <= 1'b1;
                        fifo_data  <= avm_readdata;
                        written    <= written + 19'd1;
                    end
                    if (frame_start) begin
                        late_count <= late_next;
                        base       <= fs_base;
                        state      <= ABORT;
                    end else if (written == FRAME_LAST) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                ABORT: begin
                    // Old returns are dropped; a held request still finishes its handshake.
                    avm_read <= hold;
                    if (frame_start) begin
                        late_count <= late_next;
                        base       <= fs_base;
                    end
                    if (abort_clear) begin
                        issued      <= 19'd0;
                        written     <= 19'd0;
                        avm_address <= frame_start ? fs_base : base;
                        avm_read    <= gate_base;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_fetch_sequencer.md
# frame_fetch_sequencer

Sequences reads of one 800x600 RGB565 frame from the board SDRAM into the SDRAM-to-VGA pixel FIFO. It sits in the `sdram_ctrl_clk` domain between the SDRAM controller's Avalon-MM slave and the write side of the dual-clock FIFO. On each frame-start pulse it latches the front-buffer select, streams the frame in address order, and throttles issue so the FIFO never overflows. It also recovers cleanly when a new frame starts before the current one has finished.

## Interface
Parameters:
- `FRAME_WORDS`, 480000: 16-bit pixels per frame (800x600).
- `BUF0_BASE`, 25'd0: word address of buffer 0.
- `BUF1_BASE`, 25'd524288: word address of buffer 1.
- `FIFO_DEPTH`, 512: FIFO write-side depth in words.
- `USEDW_W`, 9: width of `fifo_wrusedw`.
- `MARGIN`, 4: reserved headroom for `fifo_wrusedw` lag.

Ports:
- `clk` in 1: `sdram_ctrl_clk`. Only clock.
- `reset` in 1: asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse, already synchronous to `clk`.
- `buffer_select` in 1: front buffer; sampled only on `frame_start`.
- `fifo_wrusedw` in USEDW_W: FIFO write-side fill level.
- `fifo_wrfull` in 1: FIFO full.
- `fifo_wrreq` out 1: FIFO write strobe.
- `fifo_data` out 16: pixel to FIFO.
- `avm_address` out 25: SDRAM word address.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdata` in 16: returned pixel.
- `avm_readdatavalid` in 1: return strobe.
- `busy` out 1: state is not IDLE.
- `frame_done` out 1: one-cycle pulse when the last pixel of a frame is written.
- `late_count` out 8: saturating count of `frame_start` pulses that arrive while not IDLE.

## Operation
- States: IDLE, FETCH, DRAIN, ABORT.
- Definitions:
  - `accepted` = `avm_read && !avm_waitrequest`.
  - `outstanding` (6 bits) is +1 on `accepted` and -1 on `avm_readdatavalid`. Both in one cycle leave it unchanged.
  - `credit` = `fifo_wrusedw + outstanding + fifo_wrreq` (zero-extended to USEDW_W+2 bits).
- Issue gate: a read may be issued (raise `avm_read`) only in FETCH, when `issued < FRAME_WORDS`, `credit < FIFO_DEPTH - MARGIN`, `outstanding < 32` and `!fifo_wrfull`.
- Request hold: once raised, `avm_read` and `avm_address` stay stable until `accepted`, regardless of gate or state. This is an Avalon rule.
- IDLE:
  - On `frame_start`: latch base = `buffer_select ? BUF1_BASE : BUF0_BASE`.
  - Clear `issued` and `written`; go to FETCH.
- FETCH:
  - On `accepted`: `avm_address` += 1 and `issued` += 1.
  - When `issued` reaches FRAME_WORDS: go to DRAIN.
- DRAIN:
  - Wait until `written == FRAME_WORDS`.
  - Then pulse `frame_done` and go to IDLE.
- Return path, in FETCH and DRAIN:
  - `fifo_wrreq` <= `avm_readdatavalid`; `fifo_data` <= `avm_readdata`, registered.
  - `written` += 1 per write.
- `frame_start` in FETCH, DRAIN or ABORT:
  - `late_count` += 1, saturating at 255.
  - Re-latch base from `buffer_select`; go to ABORT.
- ABORT:
  - No new issues. A held request completes its handshake and counts in `outstanding`.
  - Returned data is discarded (`fifo_wrreq` = 0).
  - Exit to FETCH, with `issued`/`written` cleared and `avm_address` = latched base, when `outstanding == 0`, `!avm_read` and no `avm_readdatavalid` this cycle.
  - A further `frame_start` in ABORT re-latches base and increments `late_count`.
- `frame_start` coinciding with the `frame_done` cycle: the frame completes, then the new frame is handled as from IDLE. No late count.

## Timing
- Reset values: all outputs 0; state IDLE; `outstanding`, `issued`, `written` = 0; latched base = BUF0_BASE.
- IDLE to first request: `frame_start` at cycle N -> `avm_read` = 1 with `avm_address` = base at N+1, if the gate is open.
- Issue throughput: one read per cycle while `avm_waitrequest` = 0 and the gate is open.
- Return latency: `avm_readdatavalid` at cycle M -> `fifo_wrreq` at M+1.
- `frame_done`: asserted the cycle after the final `fifo_wrreq`.
- Counter widths:
  - `issued` and `written` are 19 bits.
  - `avm_address` wraps modulo 2^25. Bases must keep the frame in range; no check is performed.
- Reset mid-frame: all state is cleared immediately. Outstanding SDRAM returns after reset release are ignored (state is IDLE).

## Test plan
- Basic frame:
  - Stimulus: `buffer_select` = 0, `frame_start`, slave with 0 wait and 3-cycle latency, FIFO drained every cycle.
  - Response: addresses 0..479999 in order; exactly 480000 `fifo_wrreq`; `frame_done` once; `busy` low afterward.
- Buffer 1 and throttle:
  - Stimulus: `buffer_select` = 1, FIFO never drained.
  - Response: first address 524288; issuing stops with `credit` <= 508; no write occurs while `fifo_wrfull` = 1; no data lost after draining resumes.
- Waitrequest hold:
  - Stimulus: random `avm_waitrequest`.
  - Response: `avm_address` and `avm_read` stable through every stall; no address skipped or duplicated.
- Late frame_start:
  - Stimulus: `frame_start` at word 1000 with 5 outstanding reads.
  - Response: those 5 returns are not written; `late_count` = 1; next request addresses the new base; a full frame follows.
- Abort during a held request:
  - Stimulus: `frame_start` while `avm_read` = 1 and `avm_waitrequest` = 1.
  - Response: request held until accepted; its data is discarded; then a restart at the base.
- Async reset:
  - Stimulus: `reset` asserted mid-FETCH.
  - Response: all outputs 0 in the same cycle; after release, stray `avm_readdatavalid` produces no `fifo_wrreq`.
